// File: rtl/adder_32_bit_seq_ctrl.sv
// Byte-serial wide add/subtract sequencer.
// Reuses one 8-bit adder over N_BYTES cycles.
//
// Ports:
//   clk, rst     : clock, sync active-high reset
//   start        : request, sampled in IDLE only
//   op_sub       : 0 = a+b+cin, 1 = a-b
//   a, b, cin    : operands, latched on accept
//   busy         : high in RUN and DONE
//   done         : one-cycle completion pulse
//   sum, cout    : registered result and carry
//   overflow     : signed overflow of result

module full_adder_8_bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic       cout,
    output logic [7:0] sum
);
    assign {cout, sum} = {1'b0, a}
                       + {1'b0, b}
                       + {8'b0, cin};
endmodule

module adder_32_bit_seq_ctrl #(
    parameter int N_BYTES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               op_sub,
    input  logic [8*N_BYTES-1:0] a,
    input  logic [8*N_BYTES-1:0] b,
    input  logic               cin,
    output logic               busy,
    output logic               done,
    output logic [8*N_BYTES-1:0] sum,
    output logic               cout,
    output logic               overflow
);
    localparam int W  = 8 * N_BYTES;
    localparam int IW = $clog2(N_BYTES);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [IW-1:0] LAST =
        IW'(N_BYTES - 1);

    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic          carry_r;
    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;
    logic [W-1:0]  acc;

    logic [IW+2:0] bit0;
    logic [7:0]    fa_a;
    logic [7:0]    fa_b;
    logic [7:0]    fa_sum;
    logic          fa_cout;

    // Bit offset of the current byte slice.
    assign bit0 = {idx, 3'b000};
    assign fa_a = a_r[bit0 +: 8];
    assign fa_b = b_r[bit0 +: 8];

    full_adder_8_bit u_fa (
        .a    (fa_a),
        .b    (fa_b),
        .cin  (carry_r),
        .cout (fa_cout),
        .sum  (fa_sum)
    );

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            carry_r  <= 1'b0;
            a_r      <= '0;
            b_r      <= '0;
            acc      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r     <= a;
                        b_r     <= op_sub ? ~b : b;
                        carry_r <= op_sub | cin;
                        idx     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    acc[bit0 +: 8] <= fa_sum;
                    carry_r        <= fa_cout;
                    idx            <= idx + 1'b1;
                    if (idx == LAST) begin
                        // Top byte comes straight from
                        // the adder this cycle.
                        sum      <= {fa_sum, acc[W-9:0]};
                        cout     <= fa_cout;
                        overflow <=
                            (a_r[W-1] == b_r[W-1]) &&
                            (fa_sum[7] != a_r[W-1]);
                        idx      <= '0;
                        state    <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
